layer_argmax: RTL and testbench

//  Output-stage classifier sitting directly downstream of the last fully-connected layer.

---
 rtl/layer_argmax.sv | 119 +++++++++++
 tb/tb_layer_argmax.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_argmax.sv
// layer_argmax: captures one vector of NN signed neuron outputs and scans it
// serially, one compare per cycle. It reports the index and value of the
// largest element. On ties the lowest index wins.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a fully valid input vector
// SCAN  | walking the captured vector; commits the result when cnt==NN
// DONE  | result valid pulse cycle; may accept the next vector
module layer_argmax #(
    parameter int NN        = 10,
    parameter int dataWidth = 16,
    parameter int IDX_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             i_valid,
    input  logic [NN*dataWidth-1:0]   i_data,
    output logic                      o_valid,
    output logic [IDX_W-1:0]          o_idx,
    output logic [dataWidth-1:0]      o_max,
    output logic                      o_busy,
    output logic                      o_drop
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter is one bit wider than the index so that the value NN itself can be held.
    localparam logic [IDX_W:0] NN_CNT = (IDX_W+1)'(NN);

    state_t                      r_state;
    logic [NN*dataWidth-1:0]     r_buf;
    logic [IDX_W:0]              r_cnt;
    logic [dataWidth-1:0]        r_run_max;
    logic [IDX_W-1:0]            r_run_idx;
    logic                        r_valid;
    logic [IDX_W-1:0]            r_idx;
    logic [dataWidth-1:0]        r_max;
    logic                        r_drop;

    logic                        w_all_valid;
    logic                        w_any_valid;
    logic                        w_accept;
    logic [IDX_W-1:0]            w_cnt_idx;
    logic [dataWidth-1:0]        w_cur;
    logic                        w_greater;

    assign w_all_valid = &i_valid;
    assign w_any_valid = |i_valid;
    assign w_accept    = w_all_valid && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_idx   = r_cnt[IDX_W-1:0];
    // The element under the cursor is only consumed while cnt<NN.
    assign w_cur       = r_buf[w_cnt_idx*dataWidth +: dataWidth];
    assign w_greater   = $signed(w_cur) > $signed(r_run_max);

    // Capture, serial scan, commit, and the drop/valid pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_run_max <= '0;
            r_run_idx <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_max     <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_drop  <= w_any_valid && !w_accept;

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_SCAN: begin
                    if (r_cnt == NN_CNT) begin
                        r_idx   <= r_run_idx;
                        r_max   <= r_run_max;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        if (w_greater) begin
                            r_run_max <= w_cur;
                            r_run_idx <= w_cnt_idx;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // An accepted vector overrides the IDLE/DONE next-state choice above.
            if (w_accept) begin
                r_buf     <= i_data;
                r_run_max <= i_data[dataWidth-1:0];
                r_run_idx <= '0;
                r_cnt     <= (IDX_W+1)'(1);
                r_state   <= ST_SCAN;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_max   = r_max;
    assign o_drop  = r_drop;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_layer_argmax.sv
// Directed bench for layer_argmax. Expected results are queued when a vector
// is driven. They are popped and compared when o_valid appears.
module tb_layer_argmax;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NN-1:0]      i_valid = '0;
    logic [NN*DW-1:0]   i_data = '0;
    logic               o_valid;
    logic [IW-1:0]      o_idx;
    logic [DW-1:0]      o_max;
    logic               o_busy;
    logic               o_drop;

    layer_argmax #(.NN(NN), .dataWidth(DW), .IDX_W(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_idx   (o_idx),
        .o_max   (o_max),
        .o_busy  (o_busy),
        .o_drop  (o_drop)
    );

    always #5 clk = ~clk;

    typedef logic signed [DW-1:0] vec_t [NN];
    typedef struct {
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   nvalid = 0;
    int   last_vcyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input vec_t v);
        exp_t e;
        e.idx = '0;
        e.mx  = v[0];
        for (int k = 1; k < NN; k++) begin
            if (v[k] > $signed(e.mx)) begin
                e.mx  = v[k];
                e.idx = IW'(k);
            end
        end
        return e;
    endfunction

    // Scoreboard pop on every result pulse.
    always @(negedge clk) begin
        if (rst && o_valid) begin
            exp_t e;
            nvalid++;
            last_vcyc = cyc;
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("o_idx", 32'(o_idx), 32'(e.idx));
                check("o_max", 32'(o_max), 32'(e.mx));
            end
        end
    end

    // Drive one vector for one cycle; cap returns the edge number that sampled it.
    task automatic present(input vec_t v, input logic [NN-1:0] vm, input bit expect_accept,
                           output int cap);
        for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = v[k];
        i_valid = vm;
        if (expect_accept) sb_q.push_back(model(v));
        @(posedge clk);
        #1;
        cap = cyc;
        i_valid = '0;
        i_data  = '0;
    endtask

    task automatic wait_result(input string tag, input int c0, input int lat);
        int start;
        start = nvalid;
        for (int k = 0; k < 40 && nvalid == start; k++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_got_valid"}, 32'(nvalid > start), 32'd1);
        if (nvalid > start) check({tag, "_latency"}, 32'(last_vcyc - c0), 32'(lat));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t v;
        vec_t vd;
        int   c0;
        int   c1;
        int   t1;
        int   nv0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_idx",   32'(o_idx),   32'd0);
        check("rst_o_max",   32'(o_max),   32'd0);
        check("rst_o_busy",  32'(o_busy),  32'd0);
        check("rst_o_drop",  32'(o_drop),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(2);

        // 1: ascending k*3, result 10 cycles after capture, 1-cycle pulse
        for (int k = 0; k < NN; k++) v[k] = DW'(k * 3);
        present(v, '1, 1'b1, c0);
        @(negedge clk);
        check("t1_busy", 32'(o_busy), 32'd1);
        wait_result("t1", c0, 10);
        check("t1_idx_const", 32'(o_idx), 32'd9);
        check("t1_max_const", 32'(o_max), 32'd27);
        @(negedge clk);
        check("t1_pulse_width", 32'(o_valid), 32'd0);
        check("t1_idx_hold", 32'(o_idx), 32'd9);
        step(2);
        check("t1_idle", 32'(o_busy), 32'd0);

        // 2: tie keeps the lower index
        v = '{16'sd5, -16'sd2, 16'sd40, 16'sd40, 16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        present(v, '1, 1'b1, c0);
        wait_result("t2", c0, 10);
        check("t2_idx_const", 32'(o_idx), 32'd2);
        step(2);

        // 3: all negative, signed compare
        v = '{-16'sd100, -16'sd99, -16'sd98, -16'sd97, -16'sd91,
              -16'sd96, -16'sd95, -16'sd94, -16'sd93, -16'sd92};
        present(v, '1, 1'b1, c0);
        wait_result("t3", c0, 10);
        check("t3_max_const", 32'(o_max), 32'h0000FFA5);
        step(2);

        // 4: back-to-back, second vector presented in the o_valid cycle
        for (int k = 0; k < NN; k++) v[k] = DW'(NN - k);
        present(v, '1, 1'b1, c1);
        step(10);
        for (int k = 0; k < NN; k++) vd[k] = DW'((k == 6) ? 200 : k);
        present(vd, '1, 1'b1, c0);
        t1 = last_vcyc;
        check("t4_first_latency", 32'(t1 - c1), 32'd10);
        @(negedge clk);
        check("t4_no_drop", 32'(o_drop), 32'd0);
        check("t4_busy", 32'(o_busy), 32'd1);
        wait_result("t4b", c0, 10);
        check("t4_spacing", 32'(last_vcyc - t1), 32'd11);
        step(2);

        // 5: vector during scan is dropped; partial valid is dropped in IDLE
        for (int k = 0; k < NN; k++) v[k] = DW'(k * 7 - 20);
        present(v, '1, 1'b1, c0);
        step(2);
        for (int k = 0; k < NN; k++) vd[k] = 16'sd1000;
        present(vd, '1, 1'b0, c1);
        @(negedge clk);
        check("t5_drop_scan", 32'(o_drop), 32'd1);
        wait_result("t5", c0, 10);
        nv0 = nvalid;
        step(15);
        check("t5_no_second_valid", 32'(nvalid), 32'(nv0));
        present(vd, 10'h1FF, 1'b0, c1);
        @(negedge clk);
        check("t5_drop_partial", 32'(o_drop), 32'd1);
        check("t5_partial_idle", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("t5_drop_pulse", 32'(o_drop), 32'd0);
        step(2);

        // 6: reset in the middle of a scan
        for (int k = 0; k < NN; k++) v[k] = DW'(50 - k);
        present(v, '1, 1'b1, c0);
        step(4);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        nv0 = nvalid;
        @(negedge clk);
        check("t6_o_valid", 32'(o_valid), 32'd0);
        check("t6_o_idx",   32'(o_idx),   32'd0);
        check("t6_o_max",   32'(o_max),   32'd0);
        check("t6_o_busy",  32'(o_busy),  32'd0);
        check("t6_o_drop",  32'(o_drop),  32'd0);
        step(15);
        check("t6_no_valid", 32'(nvalid), 32'(nv0));
        for (int k = 0; k < NN; k++) v[k] = DW'((k == 3) ? -5 : -30);
        present(v, '1, 1'b1, c0);
        wait_result("t6_fresh", c0, 10);
        step(2);

        // Random vectors
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NN; k++) v[k] = DW'($urandom);
            present(v, '1, 1'b1, c0);
            wait_result("rand", c0, 10);
            step(1);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
